// File: rtl/multi_word_add_sequencer.sv
// Multi-word add/subtract sequencer.
// Computes a W = N*K bit A+B or A-B by reusing one N-bit ripple-carry adder
// over K cycles, least-significant word first, chaining the carry through a
// register between word cycles.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request valid            in_ready   request can be accepted
//   in_a/in_b  W-bit operands           in_sub     0 = A+B, 1 = A-B
//   out_valid  result valid             out_ready  consumer accepts result
//   out_sum    W-bit result (mod 2^W)   out_co     carry out (sub: 1 = no borrow)
//   out_ovf    signed overflow          busy       operation in RUN or DONE
module multi_word_add_sequencer #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   in_a,
  input  logic [N*K-1:0]   in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned W  = N * K;
  // Counter is at least one bit wide so K=1 still has a legal register.
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  a_word, b_word, c_word;
  logic          adder_co;
  logic          chain;

  // Word select plus the shared N-bit ripple-carry adder.
  always_comb begin
    a_word = '0;
    b_word = '0;
    c_word = '0;
    chain  = carry_q;
    for (int k = 0; k < K; k++) begin
      if (cnt_q == CW'(k)) begin
        a_word = a_q[k*N +: N];
        b_word = b_q[k*N +: N];
      end
    end
    for (int i = 0; i < N; i++) begin
      c_word[i] = a_word[i] ^ b_word[i] ^ chain;
      chain     = (a_word[i] & b_word[i]) | (chain & (a_word[i] ^ b_word[i]));
    end
    adder_co = chain;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry-in.
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < K; k++) begin
          if (cnt_q == CW'(k)) sum_d[k*N +: N] = c_word;
        end
        carry_d = adder_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
          co_d    = adder_co;
          // Overflow uses the post-inversion B and the just-completed top word.
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (sum_d[W-1] != a_q[W-1]);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multi_word_add_sequencer.sv
// Self-checking bench for multi_word_add_sequencer (N=8, K=4, W=32).
// Directed cases from the test plan plus randomized operations checked
// against an arithmetic reference model.
module tb_multi_word_add_sequencer;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;
  localparam int unsigned W = N * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co, out_ovf, busy;

  int total = 0;
  int bad   = 0;

  multi_word_add_sequencer #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, signed range test for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] sum, output logic co, output logic ovf);
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      r  = ua + ub;
      co = r[32];
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end
    sum = r[31:0];
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  // One full operation; hold > 0 adds back-pressure and stray in_valid pulses.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int hold);
    logic [W-1:0] es;
    logic         eco, eov;
    int           n;
    model(a, b, s, es, eco, eov);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_accept_wait"}, W'(n < 20), W'(1));
    step();  // accept edge
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_sub = ~s;  // must be ignored after accept
    chk({tag, "_busy_run"}, W'(busy), W'(1));
    chk({tag, "_in_ready_run"}, W'(in_ready), W'(0));
    for (int i = 1; i < K; i++) begin
      if (hold > 0) in_valid = 1'b1;
      step();
    end
    chk({tag, "_valid_early"}, W'(out_valid), W'(0));
    step();
    chk({tag, "_valid_on_time"}, W'(out_valid), W'(1));
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_co"}, W'(out_co), W'(eco));
    chk({tag, "_ovf"}, W'(out_ovf), W'(eov));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      step();
      chk({tag, "_hold_valid"}, W'(out_valid), W'(1));
      chk({tag, "_hold_sum"}, out_sum, es);
      chk({tag, "_hold_flags"}, W'({out_co, out_ovf}), W'({eco, eov}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, W'(out_valid), W'(0));
    chk({tag, "_ready_back"}, W'(in_ready), W'(1));
    chk({tag, "_busy_idle"}, W'(busy), W'(0));
    chk({tag, "_sum_held"}, out_sum, es);
    if (hold > 0) begin
      step();
      chk({tag, "_no_queued"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_sum", out_sum, W'(0));
    chk("rst_flags", W'({out_co, out_ovf}), W'(0));

    run_op("add_ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op("backpressure", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 10);

    // Reset while in RUN with the counter at word 2.
    in_a = 32'hDEAD_BEEF; in_b = 32'h0101_0101; in_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_sum", out_sum, W'(0));
    chk("midrst_flags", W'({out_co, out_ovf}), W'(0));
    step();
    chk("midrst_stays_idle", W'(in_ready), W'(1));
    run_op("after_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1, 0));
      if (i % 6 == 0) rb = ra;  // exercise equal-operand subtract
      run_op("rand", ra, rb, rs, (i % 8 == 7) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
